// File: rtl/i2c_cfg_pkg.sv
// i2c_cfg_pkg: shared states, quarter-phase codes and transfer geometry for the I2C config master.
package i2c_cfg_pkg;
  typedef enum logic [2:0] {IDLE, START, BIT, ACKS, STOP, DONE} state_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam int BYTES_PER_XFER = 3;
  localparam int BITS_PER_BYTE = 8;
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: free-running divider giving a one-cycle quarter-bit tick every QDIV clocks.
module i2c_tick_gen #(
  parameter int QDIV = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);
  localparam int W = (QDIV < 2) ? 1 : $clog2(QDIV);
  logic [W-1:0] cnt_q, cnt_d;
  if (QDIV < 1) begin : g_bad_qdiv
    $error("i2c_tick_gen: QDIV must be >= 1");
  end
  assign tick = cnt_q == W'(QDIV - 1);
  always_comb cnt_d = tick ? '0 : cnt_q + W'(1);
  always_ff @(posedge CLOCK_50) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/i2c_cfg_master.sv
// i2c_cfg_master: writes one {slave, sub, data} word per GO/END handshake as an I2C write.
// Define I2C_NACK_ABORT_EN to cut the transfer short to STOP after the first NACK.
module i2c_cfg_master
  import i2c_cfg_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000,
  parameter int QDIV = CLK_FREQ / (4 * I2C_FREQ)
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [23:0] I2C_DATA,
  input  logic        GO,
  output logic        END,
  output logic        ACK,
  output logic        BUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_XFER - 1);
  localparam logic [2:0] TOP_BIT = 3'(BITS_PER_BYTE - 1);
  state_t state_q, state_d;
  logic [1:0] q_q, q_d, byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [23:0] sh_q, sh_d;
  logic acc_q, acc_d, end_q, end_d, ack_q, ack_d, busy_q, busy_d;
  logic scl_q, scl_d, oe_q, oe_d;
  logic tick, last_byte;
  i2c_tick_gen #(.QDIV(QDIV)) u_tick (.CLOCK_50(CLOCK_50), .reset(reset), .tick(tick));
`ifdef I2C_NACK_ABORT_EN
  assign last_byte = (byte_q == LAST_BYTE) || acc_q;
`else
  assign last_byte = byte_q == LAST_BYTE;
`endif
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    bit_d = bit_q;
    byte_d = byte_q;
    sh_d = sh_q;
    acc_d = acc_q;
    end_d = end_q;
    ack_d = ack_q;
    busy_d = busy_q;
    if (state_q == IDLE) begin
      if (GO) begin
        state_d = START;
        q_d = Q0;
        sh_d = I2C_DATA;
        acc_d = 1'b0;
        end_d = 1'b0;
        busy_d = 1'b1;
      end
    end else if (state_q == DONE) begin
      if (!GO) state_d = IDLE;
    end else if (tick) begin
      q_d = q_q + 2'd1;
      // Anything but a solid low during the high SCL of the ACK slot is a NACK.
      if (state_q == ACKS && q_q == Q2) acc_d = acc_q | (I2C_SDAT !== 1'b0);
      if (q_q == Q3) begin
        case (state_q)
          START: begin
            state_d = BIT;
            bit_d = TOP_BIT;
            byte_d = 2'd0;
          end
          BIT: begin
            sh_d = sh_q << 1;
            state_d = (bit_q == 3'd0) ? ACKS : BIT;
            bit_d = bit_q - 3'd1;
          end
          ACKS: begin
            state_d = last_byte ? STOP : BIT;
            bit_d = TOP_BIT;
            byte_d = last_byte ? byte_q : byte_q + 2'd1;
          end
          STOP: begin
            state_d = DONE;
            end_d = 1'b1;
            busy_d = 1'b0;
            ack_d = acc_q;
          end
          default: ;
        endcase
      end
    end
    // Line levels are a pure function of the position being entered, so they stay registered.
    scl_d = 1'b1;
    oe_d = 1'b0;
    case (state_d)
      START: begin
        scl_d = q_d != Q3;
        oe_d = q_d != Q0;
      end
      BIT: begin
        scl_d = q_d == Q1 || q_d == Q2;
        oe_d = ~sh_d[23];
      end
      ACKS: scl_d = q_d == Q1 || q_d == Q2;
      STOP: begin
        scl_d = q_d != Q0;
        oe_d = q_d == Q0 || q_d == Q1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      q_q <= Q0;
      bit_q <= '0;
      byte_q <= '0;
      sh_q <= '0;
      acc_q <= 1'b0;
      end_q <= 1'b1;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
      scl_q <= 1'b1;
      oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      sh_q <= sh_d;
      acc_q <= acc_d;
      end_q <= end_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
      scl_q <= scl_d;
      oe_q <= oe_d;
    end
  end
  assign END = end_q;
  assign ACK = ack_q;
  assign BUSY = busy_q;
  assign I2C_SCLK = scl_q;
  assign I2C_SDAT = oe_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_cfg_master.sv
// tb_i2c_cfg_master: directed checks of the I2C config master with a bus monitor and ACKing slave.
module tb_i2c_cfg_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [23:0] I2C_DATA = '0;
  logic GO = 1'b0;
  logic END, ACK, BUSY, scl;
  wire sda;
  logic sl_drv = 1'b0;
  logic [3:0] ack_mask = 4'hf;
  int vectors = 0, miscompares = 0;
  int starts = 0, stops = 0, bitpos = 0, byte_idx = 0;
  logic [7:0] rx [4];
  logic [7:0] shreg = '0;
  logic ps = 1'b1, pd = 1'b1;
  int len, n;

  pullup (sda);
  assign sda = sl_drv ? 1'b0 : 1'bz;

  i2c_cfg_master #(.CLK_FREQ(800), .I2C_FREQ(100)) dut (
    .CLOCK_50(clk), .reset(reset), .I2C_DATA(I2C_DATA), .GO(GO),
    .END(END), .ACK(ACK), .BUSY(BUSY), .I2C_SCLK(scl), .I2C_SDAT(sda)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave: decodes bytes, spots START/STOP, pulls SDA low in ACK slots per ack_mask.
  initial forever begin
    @(negedge clk);
    if (scl && ps && pd && !sda) begin starts++; bitpos = 0; byte_idx = 0; end
    if (scl && ps && !pd && sda) stops++;
    if (scl && !ps) begin
      if (bitpos < 8) shreg = {shreg[6:0], sda};
      bitpos++;
      if (bitpos == 9) begin
        if (byte_idx < 4) rx[byte_idx] = shreg;
        byte_idx++;
        bitpos = 0;
      end
    end
    if (!scl && ps) begin
      if (bitpos == 8) sl_drv = (byte_idx < 4) ? ack_mask[byte_idx] : 1'b0;
      else if (bitpos == 0) sl_drv = 1'b0;
    end
    ps = scl;
    pd = sda;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [23:0] d, input logic [3:0] m, output int cycles);
    ack_mask = m;
    starts = 0;
    stops = 0;
    byte_idx = 0;
    cycles = 0;
    @(negedge clk);
    I2C_DATA = d;
    GO = 1'b1;
    @(negedge clk);
    chk("accept_end", END, 0);
    chk("accept_busy", BUSY, 1);
    while (!END && cycles < 1000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic drop_go;
    @(negedge clk);
    GO = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_end", END, 1);
    chk("rst_ack", ACK, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    reset = 1'b0;

    // All bytes ACKed: 116 quarters of 2 cycles, first quarter may be one cycle short.
    xfer(24'h340E05, 4'hf, len);
    chk("ack_len", (len >= 230 && len <= 234), 1);
    chk("ack_b0", rx[0], 8'h34);
    chk("ack_b1", rx[1], 8'h0E);
    chk("ack_b2", rx[2], 8'h05);
    chk("ack_slots", byte_idx, 3);
    chk("ack_start", starts, 1);
    chk("ack_stop", stops, 1);
    chk("ack_flag", ACK, 0);
    chk("ack_busy", BUSY, 0);

    // GO held after END: no second transfer.
    repeat (500) @(negedge clk);
    chk("hold_start", starts, 1);
    chk("hold_end", END, 1);
    chk("hold_scl", scl, 1);
    drop_go();
    xfer(24'h401741, 4'hf, len);
    chk("hs_len", (len >= 230 && len <= 234), 1);
    chk("hs_b0", rx[0], 8'h40);
    chk("hs_b1", rx[1], 8'h17);
    chk("hs_b2", rx[2], 8'h41);
    chk("hs_ack", ACK, 0);
    drop_go();

    // Slave NACKs the sub-address.
    xfer(24'h340E05, 4'b1101, len);
    chk("nack_flag", ACK, 1);
    chk("nack_stop", stops, 1);
`ifdef I2C_NACK_ABORT_EN
    chk("nack_len", (len >= 158 && len <= 162), 1);
    chk("nack_slots", byte_idx, 2);
`else
    chk("nack_len", (len >= 230 && len <= 234), 1);
    chk("nack_slots", byte_idx, 3);
    chk("nack_b2", rx[2], 8'h05);
`endif
    drop_go();

    // Reset during byte 1; ACK is still 1 from the NACK transfer and must clear.
    ack_mask = 4'hf;
    @(negedge clk);
    I2C_DATA = 24'h340E05;
    GO = 1'b1;
    n = 0;
    while (!(byte_idx == 1 && bitpos == 5) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("mid_reached", (n < 1000), 1);
    reset = 1'b1;
    GO = 1'b0;
    @(negedge clk);
    chk("mid_scl", scl, 1);
    chk("mid_sda", sda, 1);
    chk("mid_end", END, 1);
    chk("mid_ack", ACK, 0);
    chk("mid_busy", BUSY, 0);
    reset = 1'b0;
    xfer(24'h340E05, 4'hf, len);
    chk("post_len", (len >= 230 && len <= 234), 1);
    chk("post_b1", rx[1], 8'h0E);
    chk("post_ack", ACK, 0);
    drop_go();

    // No slave: pull-up makes every ACK slot read high.
    xfer(24'h2A5501, 4'h0, len);
    chk("nos_flag", ACK, 1);
    chk("nos_b0", rx[0], 8'h2A);
`ifdef I2C_NACK_ABORT_EN
    chk("nos_len", (len >= 86 && len <= 90), 1);
    chk("nos_slots", byte_idx, 1);
`else
    chk("nos_len", (len >= 230 && len <= 234), 1);
    chk("nos_slots", byte_idx, 3);
    chk("nos_b2", rx[2], 8'h01);
`endif
    drop_go();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
